// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline and the hazard/sequencing controller.
// The master side is the pipeline datapath; the slave side is the controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             br_taken;
  logic             mem_dren;
  logic             mem_dwen;
  logic             dhit;
  logic             ihit;
  logic             mem_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, ex_rd, ex_memread, br_taken,
           mem_dren, mem_dwen, dhit, ihit, mem_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rd, ex_memread, br_taken,
           mem_dren, mem_dwen, dhit, ihit, mem_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubble, branch flush, cache-wait freeze,
// sticky halt, plus saturating stall/flush performance counters.
//
//  state     | meaning
//  S_RUN     | normal issue, all hazard rules evaluated
//  S_LUSTALL | one cycle after a load-use bubble; load-use ignored
//  S_DWAIT   | full freeze until the D-cache completes
//  S_HALT    | core stopped; only reset leaves
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_LUSTALL = 2'd1,
    S_DWAIT   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
  logic exmem_en_c, exmem_flush_c, memwb_en_c;
  logic flush_evt_c;
  logic dacc, lu;

  assign dacc = bus.mem_dren | bus.mem_dwen;
  assign lu   = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));

  always_comb begin
    state_d       = state_q;
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    idex_en_c     = 1'b1;
    exmem_en_c    = 1'b1;
    memwb_en_c    = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    flush_evt_c   = 1'b0;

    case (state_q)
      S_RUN, S_LUSTALL: begin
        state_d = S_RUN;
        if (bus.mem_halt) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
          state_d = S_HALT;
        end else if (dacc && !bus.dhit) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
          state_d = S_DWAIT;
        end else if (bus.br_taken) begin
          // Redirect wins over a missing fetch: the target is loaded regardless of ihit.
          ifid_flush_c  = 1'b1;
          idex_flush_c  = 1'b1;
          exmem_flush_c = 1'b1;
          flush_evt_c   = 1'b1;
        end else if (lu && (state_q == S_RUN)) begin
          pc_en_c      = 1'b0;
          ifid_en_c    = 1'b0;
          idex_flush_c = 1'b1;
          state_d      = S_LUSTALL;
        end else if (!bus.ihit) begin
          pc_en_c      = 1'b0;
          ifid_flush_c = 1'b1;
        end
      end
      S_DWAIT: begin
        if (!bus.dhit) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
        state_d = S_HALT;
      end
    endcase
  end

  // The halt-entry cycle is excluded from the stall count, hence state_d rather than state_q.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en_c && (state_d != S_HALT) && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt_c && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en_c       & nRST;
  assign bus.ifid_en     = ifid_en_c     & nRST;
  assign bus.ifid_flush  = ifid_flush_c  & nRST;
  assign bus.idex_en     = idex_en_c     & nRST;
  assign bus.idex_flush  = idex_flush_c  & nRST;
  assign bus.exmem_en    = exmem_en_c    & nRST;
  assign bus.exmem_flush = exmem_flush_c & nRST;
  assign bus.memwb_en    = memwb_en_c    & nRST;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver pushes model predictions, a negedge monitor
// pops and compares. Small counter width so saturation is reachable.
module tb_hazard_ctrl;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus();
  hazard_ctrl #(.CNT_W(CW)) dut (.CLK(clk), .nRST(nrst), .bus(bus.slave));

  // en vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en
  typedef struct packed {
    logic [7:0] en;
    logic       halted;
    int         st;
    int         fl;
  } exp_t;

  localparam logic [7:0] E_FREEZE = 8'b0000_0000;
  localparam logic [7:0] E_DEF    = 8'b1101_0101;
  localparam logic [7:0] E_BR     = 8'b1111_1111;
  localparam logic [7:0] E_LU     = 8'b0001_1101;
  localparam logic [7:0] E_IMISS  = 8'b0111_0101;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // reference model: a few facts about the pipeline, not a state register
  bit m_halted, m_waiting_d, m_just_bubbled;
  int m_st, m_fl;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(input bit rst_n, input int rs, input int rt, input int rd,
                      input bit memrd, input bit br, input bit dren, input bit dwen,
                      input bit dh, input bit ih, input bit hlt);
    exp_t x;
    bit   lu, bubble_now, halted_before;
    nrst           = rst_n;
    bus.id_rs      = 5'(rs);
    bus.id_rt      = 5'(rt);
    bus.ex_rd      = 5'(rd);
    bus.ex_memread = memrd;
    bus.br_taken   = br;
    bus.mem_dren   = dren;
    bus.mem_dwen   = dwen;
    bus.dhit       = dh;
    bus.ihit       = ih;
    bus.mem_halt   = hlt;

    lu = memrd && (rd != 0) && (rd == rs || rd == rt);
    bubble_now = 1'b0;
    halted_before = m_halted;
    x.halted = rst_n ? m_halted : 1'b0;
    x.st = rst_n ? m_st : 0;
    x.fl = rst_n ? m_fl : 0;

    if (!rst_n) begin
      x.en = E_FREEZE;
      m_halted = 0; m_waiting_d = 0; m_st = 0; m_fl = 0;
    end else begin
      if (m_halted) x.en = E_FREEZE;
      else if (m_waiting_d) begin
        x.en = dh ? E_DEF : E_FREEZE;
        m_waiting_d = !dh;
      end
      else if (hlt) begin x.en = E_FREEZE; m_halted = 1; end
      else if ((dren || dwen) && !dh) begin x.en = E_FREEZE; m_waiting_d = 1; end
      else if (br) begin
        x.en = E_BR;
        if (m_fl < SAT) m_fl++;
      end
      else if (lu && !m_just_bubbled) begin x.en = E_LU; bubble_now = 1; end
      else if (!ih) x.en = E_IMISS;
      else x.en = E_DEF;
      if (!x.en[7] && !halted_before && !m_halted && m_st < SAT) m_st++;
    end
    m_just_bubbled = bubble_now;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic rand_step(input bit allow_halt);
    bit r;
    r = ($urandom_range(0, 149) != 0);
    step(r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
         $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
         $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
         $urandom_range(0, 1) == 0, $urandom_range(0, 3) != 0,
         allow_halt && ($urandom_range(0, 199) == 0));
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk("en_flush_vec", {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                           bus.idex_flush, bus.exmem_en, bus.exmem_flush, bus.memwb_en}, x.en);
      chk("halted", bus.halted, x.halted);
      chk("stall_cnt", bus.stall_cnt, x.st);
      chk("flush_cnt", bus.flush_cnt, x.fl);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.id_rs = 0; bus.id_rt = 0; bus.ex_rd = 0; bus.ex_memread = 0;
    bus.br_taken = 0; bus.mem_dren = 0; bus.mem_dwen = 0;
    bus.dhit = 1; bus.ihit = 1; bus.mem_halt = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(1);
    // load-use on rs, held for two cycles: second cycle must not stall again
    step(1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 0);
    step(1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 0);
    idle(1);
    // load-use on rt, and a load to $0 that must not stall
    step(1, 5, 3, 3, 1, 0, 0, 0, 1, 1, 0);
    idle(1);
    step(1, 0, 2, 0, 1, 0, 0, 0, 1, 1, 0);
    idle(1);
    // D-cache wait: three misses, then the hit cycle; lu during wait ignored
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(1, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    idle(1);
    // branch beats load-use and I-miss in the same cycle
    step(1, 2, 0, 2, 1, 1, 0, 0, 1, 0, 0);
    idle(1);
    // saturation of both counters
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    // sticky halt, then reset mid-halt
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) rand_step(0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    // randomized run
    for (int i = 0; i < 1500; i++) rand_step(1);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
